// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
// Steers the program counter around branches: straight-line fetch, taken
// unconditional/register redirects, conditional-branch resolution with a
// one-cycle wait for the condition, a fixed-length flush bubble after every
// taken redirect, and a terminal HALT state.
//
// Parameters
//   FLUSH_CYCLES : bubble cycles after a taken redirect (1..15)
//   CNT_W        : width of the taken-redirect counter
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   br_type    in   2  branch class: 00 none, 01 B, 10 conditional, 11 BR
//   cond_taken in   1  condition result, used only while resolving
//   stall_req  in   1  external stall, freezes PC and state
//   halt       in   1  halt decoded, used only in RUN
//   pc_en      out  1  PC update enable (combinational)
//   pc_src     out  2  PC next-select (combinational)
//   flush      out  1  kill fetched/decoded instruction (combinational)
//   state      out  2  RUN 00, RESOLVE 01, FLUSH 10, HALT 11
//   taken_cnt  out  CNT_W  taken redirect count
//
// Build option
//   FETCH_CTRL_PERF_EN : when defined, taken_cnt is a saturating counter of
//                        entries into FLUSH; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module fetch_controller #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       br_type,
    input  logic             cond_taken,
    input  logic             stall_req,
    input  logic             halt,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_RESOLVE = 2'b01,
        ST_FLUSH   = 2'b10,
        ST_HALT    = 2'b11
    } state_t;

    // The flush counter counts down to zero, so it starts one below the
    // residency to give exactly FLUSH_CYCLES cycles in FLUSH.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state_r;
    logic [3:0] flush_cnt_r;
    logic       enter_flush_s;

    assign state = state_r;

    // Detect a taken redirect that moves the FSM into FLUSH on the next edge.
    always_comb begin
        enter_flush_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (!halt && !stall_req && (br_type == 2'b01 || br_type == 2'b11)) begin
                    enter_flush_s = 1'b1;
                end else begin
                    enter_flush_s = 1'b0;
                end
            end
            ST_RESOLVE: begin
                if (!stall_req && cond_taken) begin
                    enter_flush_s = 1'b1;
                end else begin
                    enter_flush_s = 1'b0;
                end
            end
            default: enter_flush_s = 1'b0;
        endcase
    end

    // PC control outputs; gated by reset so they drop to zero asynchronously.
    always_comb begin
        pc_en  = 1'b0;
        pc_src = 2'b00;
        flush  = 1'b0;
        if (!reset) begin
            pc_en  = 1'b0;
            pc_src = 2'b00;
            flush  = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    // halt and stall both freeze the PC; br_type is ignored then
                    if (halt || stall_req) begin
                        pc_en = 1'b0;
                    end else if (br_type == 2'b10) begin
                        pc_en = 1'b0;
                    end else begin
                        pc_en  = 1'b1;
                        pc_src = br_type;
                    end
                end
                ST_RESOLVE: begin
                    if (stall_req) begin
                        pc_en = 1'b0;
                    end else if (cond_taken) begin
                        pc_en  = 1'b1;
                        pc_src = 2'b10;
                    end else begin
                        pc_en  = 1'b1;
                        pc_src = 2'b00;
                    end
                end
                ST_FLUSH: flush = 1'b1;
                default: begin
                    pc_en  = 1'b0;
                    pc_src = 2'b00;
                    flush  = 1'b0;
                end
            endcase
        end
    end

    // State register and flush bubble counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_RUN;
            flush_cnt_r <= 4'd0;
        end else if (enter_flush_s) begin
            state_r     <= ST_FLUSH;
            flush_cnt_r <= FLUSH_LOAD;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (halt) begin
                        state_r <= ST_HALT;
                    end else if (!stall_req && br_type == 2'b10) begin
                        state_r <= ST_RESOLVE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RESOLVE: begin
                    // a taken condition was handled above; here it is not-taken
                    if (!stall_req) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_RESOLVE;
                    end
                end
                ST_FLUSH: begin
                    // stall_req deliberately does not stretch the bubble
                    if (flush_cnt_r == 4'd0) begin
                        state_r <= ST_RUN;
                    end else begin
                        flush_cnt_r <= flush_cnt_r - 4'd1;
                    end
                end
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_RUN;
            endcase
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [CNT_W-1:0] taken_cnt_r;

    // Saturating count of taken redirects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_cnt_r <= {CNT_W{1'b0}};
        end else if (enter_flush_s && (taken_cnt_r != {CNT_W{1'b1}})) begin
            taken_cnt_r <= taken_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            taken_cnt_r <= taken_cnt_r;
        end
    end

    assign taken_cnt = taken_cnt_r;
`else
    assign taken_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model that tracks the current phase, the number of
// bubble cycles still owed, and a plain integer count of taken redirects.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

    localparam int FC = 3;
    localparam int CW = 2;

    localparam int P_RUN     = 0;
    localparam int P_RESOLVE = 1;
    localparam int P_FLUSH   = 2;
    localparam int P_HALT    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    br_type = 2'b00;
    logic          cond_taken = 1'b0;
    logic          stall_req = 1'b0;
    logic          halt = 1'b0;
    logic          pc_en;
    logic [1:0]    pc_src;
    logic          flush;
    logic [1:0]    state;
    logic [CW-1:0] taken_cnt;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // model
    int m_phase = P_RUN;
    int m_owed  = 0;
    int m_taken = 0;
    int halt_cycles = 0;

    fetch_controller #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .br_type   (br_type),
        .cond_taken(cond_taken),
        .stall_req (stall_req),
        .halt      (halt),
        .pc_en     (pc_en),
        .pc_src    (pc_src),
        .flush     (flush),
        .state     (state),
        .taken_cnt (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int got, input int exp);
        total_cnt++;
        if (got != exp) begin
            bad_cnt++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    function automatic int exp_taken();
`ifdef FETCH_CTRL_PERF_EN
        int lim = (1 << CW) - 1;
        return (m_taken > lim) ? lim : m_taken;
`else
        return 0;
`endif
    endfunction

    // Assert reset away from the clock edge and verify the immediate effect.
    task automatic do_reset();
        @(negedge clk);
        #2;
        br_type = 2'b00; cond_taken = 1'b0; stall_req = 1'b0; halt = 1'b0;
        reset = 1'b0;
        #1;
        m_phase = P_RUN; m_owed = 0; m_taken = 0; halt_cycles = 0;
        chk_eq("rst_state", int'(state), 0);
        chk_eq("rst_pc_en", int'(pc_en), 0);
        chk_eq("rst_pc_src", int'(pc_src), 0);
        chk_eq("rst_flush", int'(flush), 0);
        chk_eq("rst_taken", int'(taken_cnt), 0);
        @(negedge clk);
        #1;
        chk_eq("rst_hold_state", int'(state), 0);
        chk_eq("rst_hold_pc_en", int'(pc_en), 0);
        reset = 1'b1;
    endtask

    // One clock of stimulus: apply inputs, compare against the model, advance.
    task automatic run_cycle(input logic [1:0] bt, input logic ct, input logic st, input logic hl);
        int  e_en, e_src, e_fl, nxt;
        bit  taken;
        @(negedge clk);
        br_type = bt; cond_taken = ct; stall_req = st; halt = hl;
        #1;
        e_en = 0; e_src = 0; e_fl = 0; nxt = m_phase; taken = 1'b0;
        case (m_phase)
            P_RUN: begin
                if (hl) nxt = P_HALT;
                else if (st) nxt = P_RUN;
                else if (bt == 2'b00) e_en = 1;
                else if (bt == 2'b10) nxt = P_RESOLVE;
                else begin e_en = 1; e_src = int'(bt); taken = 1'b1; end
            end
            P_RESOLVE: begin
                if (st) nxt = P_RESOLVE;
                else if (ct) begin e_en = 1; e_src = 2; taken = 1'b1; end
                else begin e_en = 1; nxt = P_RUN; end
            end
            P_FLUSH: begin
                e_fl = 1;
                if (m_owed == 1) nxt = P_RUN;
            end
            default: nxt = P_HALT;
        endcase
        chk_eq("pc_en", int'(pc_en), e_en);
        chk_eq("pc_src", int'(pc_src), e_src);
        chk_eq("flush", int'(flush), e_fl);
        chk_eq("state", int'(state), m_phase);
        chk_eq("taken_cnt", int'(taken_cnt), exp_taken());
        @(posedge clk);
        if (m_phase == P_FLUSH) m_owed--;
        if (taken) begin
            nxt = P_FLUSH;
            m_owed = FC;
            m_taken++;
        end
        halt_cycles = (nxt == P_HALT) ? halt_cycles + 1 : 0;
        m_phase = nxt;
    endtask

    initial begin
        do_reset();
        // straight-line fetch
        repeat (3) run_cycle(2'b00, 1'b0, 1'b0, 1'b0);
        // unconditional branch then bubble
        run_cycle(2'b01, 1'b0, 1'b0, 1'b0);
        repeat (FC + 1) run_cycle(2'b00, 1'b0, 1'b0, 1'b0);
        // conditional taken / not taken
        run_cycle(2'b10, 1'b0, 1'b0, 1'b0);
        run_cycle(2'b00, 1'b1, 1'b0, 1'b0);
        repeat (FC + 1) run_cycle(2'b00, 1'b0, 1'b0, 1'b0);
        run_cycle(2'b10, 1'b0, 1'b0, 1'b0);
        run_cycle(2'b00, 1'b0, 1'b0, 1'b0);
        run_cycle(2'b00, 1'b0, 1'b0, 1'b0);
        // stall while resolving, condition ignored during stall
        run_cycle(2'b10, 1'b0, 1'b0, 1'b0);
        run_cycle(2'b01, 1'b1, 1'b1, 1'b1);
        run_cycle(2'b11, 1'b0, 1'b1, 1'b0);
        run_cycle(2'b00, 1'b1, 1'b0, 1'b0);
        // stall and branch noise during bubble must not stretch it
        run_cycle(2'b11, 1'b1, 1'b1, 1'b1);
        run_cycle(2'b01, 1'b0, 1'b1, 1'b0);
        run_cycle(2'b00, 1'b0, 1'b0, 1'b0);
        // stall in RUN ignores branch
        run_cycle(2'b01, 1'b0, 1'b1, 1'b0);
        // saturation: several back-to-back taken redirects
        repeat (5) begin
            run_cycle(2'b11, 1'b0, 1'b0, 1'b0);
            repeat (FC) run_cycle(2'b00, 1'b0, 1'b0, 1'b0);
        end
        // halt beats a register branch, then stays put
        run_cycle(2'b11, 1'b0, 1'b0, 1'b1);
        repeat (5) run_cycle(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
        do_reset();
        run_cycle(2'b00, 1'b0, 1'b0, 1'b0);
        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            if (halt_cycles > 3 || $urandom_range(0, 150) == 0) begin
                do_reset();
            end else begin
                run_cycle(2'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 60) == 0));
            end
        end
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 1, bubble cycles after a taken redirect (legal 1..15).
REQ-002 Parameter: CNT_W, default 16, width of taken-branch counter.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 br_type  input  2  decoded branch class: 00 none, 01 B (uncond), 10 conditional (CBZ/B.cond), 11 BR (register).
REQ-007 cond_taken  input  1  condition result; sampled only in RESOLVE.
REQ-008 stall_req  input  1  external stall; freezes PC and state.
REQ-009 halt  input  1  halt instruction decoded; sampled only in RUN.
REQ-010 pc_en  output  1  program-counter update enable.
REQ-011 pc_src  output  2  PC next-select: 00 pc+4, 01 uncond offset, 10 cond offset, 11 register.
REQ-012 flush  output  1  kill the fetched/decoded instruction this cycle.
REQ-013 state  output  2  current state: RUN 00, RESOLVE 01, FLUSH 10, HALT 11.
REQ-014 taken_cnt  output  CNT_W  count of taken redirects (see Configuration).

Function
REQ-015 Outputs pc_en, pc_src, flush SHALL be combinational from state and current inputs; state, flush counter, taken_cnt SHALL be registered.
REQ-016 Priority in RUN: halt > stall_req > br_type.
REQ-017 RUN, halt=1: pc_en=0, pc_src=00; next state HALT.
REQ-018 RUN, stall_req=1 (halt=0): pc_en=0, pc_src=00; state held.
REQ-019 RUN, br_type=00: pc_en=1, pc_src=00; stay RUN.
REQ-020 RUN, br_type=01 or 11: pc_en=1, pc_src=br_type; next FLUSH, flush counter loaded with FLUSH_CYCLES-1.
REQ-021 RUN, br_type=10: pc_en=0, pc_src=00; next RESOLVE.
REQ-022 RESOLVE, stall_req=1: pc_en=0; state held; cond_taken ignored.
REQ-023 RESOLVE, cond_taken=1: pc_en=1, pc_src=10; next FLUSH, counter loaded FLUSH_CYCLES-1.
REQ-024 RESOLVE, cond_taken=0: pc_en=1, pc_src=00; next RUN.
REQ-025 FLUSH: pc_en=0, pc_src=00, flush=1; counter decrements each cycle; at 0 next state RUN. Total FLUSH residency = FLUSH_CYCLES cycles; stall_req does not extend it.
REQ-026 halt, br_type in RESOLVE/FLUSH SHALL be ignored; br_type in RUN during stall SHALL be ignored (re-presented by decode).
REQ-027 HALT: pc_en=0, pc_src=00, flush=0; terminal until reset.
REQ-028 flush SHALL be 0 in every state except FLUSH.

Reset
REQ-029 reset=0 SHALL immediately (asynchronously) force state=RUN, flush counter=0, taken_cnt=0, pc_en=0, pc_src=00, flush=0, including mid-RESOLVE/FLUSH/HALT.
REQ-030 First rising edge after reset=1 behaves as RUN per REQ-016..021.

Configuration
REQ-031 Macro FETCH_CTRL_PERF_EN: when defined, taken_cnt increments by 1 on each clock edge entering FLUSH (REQ-020, REQ-023), saturating at all-ones.
REQ-032 Without FETCH_CTRL_PERF_EN, taken_cnt SHALL be constant 0 and no counter register SHALL exist; all other behaviour identical.

Verification
REQ-033 Reset released, br_type=00 for 3 cycles -> pc_en=1, pc_src=00 each cycle, state=00, flush=0.
REQ-034 RUN, br_type=01 one cycle, FLUSH_CYCLES=1 -> pc_src=01,pc_en=1; next cycle state=10, flush=1, pc_en=0; then state=00.
REQ-035 br_type=10 then cond_taken=1 -> cycle1 pc_en=0 state=00->01; cycle2 pc_src=10 pc_en=1; cycle3 flush=1; with cond_taken=0 cycle2 pc_src=00 and no flush.
REQ-036 RESOLVE with stall_req=1 for 2 cycles then cond_taken=1 -> pc_en=0 two cycles, state=01 held, then pc_src=10.
REQ-037 halt=1 with br_type=11 in RUN -> pc_en=0, state=11 next and held 5 cycles; reset pulse low mid-HALT -> state=00 immediately.
REQ-038 With FETCH_CTRL_PERF_EN, CNT_W=2: 5 taken branches -> taken_cnt 1,2,3,3,3; without macro taken_cnt=0 throughout.
